// File: rtl/yolo_max_pool_top_hls_deadlock_detector.sv
// Debounces the raw HLS monitor block flags and latches a sticky deadlock report
// once blocking persists for THRESHOLD cycles with no forward progress.
module yolo_max_pool_top_hls_deadlock_detector #(
  parameter int NUM_MON   = 4,
  parameter int THRESHOLD = 1024,
  parameter int CNT_W     = 16,
  parameter int IDX_W     = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               progress,
  input  logic               clear,
  output logic               deadlock,
  output logic               report_valid,
  output logic [IDX_W-1:0]   deadlock_idx,
  output logic [NUM_MON-1:0] block_vec,
  output logic [CNT_W-1:0]   block_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    SUSPECT,
    DETECTED
  } state_t;

  state_t             state_q, state_d;
  logic               deadlock_q, deadlock_d;
  logic               reportValid_q, reportValid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_MON-1:0] vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               anyBlock;
  logic [IDX_W-1:0]   lowIdx;

  assign anyBlock = |mon_block;

  // Downward scan so the lowest set bit is the last one written and wins.
  always_comb begin
    lowIdx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (mon_block[i]) lowIdx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    deadlock_d    = deadlock_q;
    reportValid_d = 1'b0;
    idx_d         = idx_q;
    vec_d         = vec_q;
    cnt_d         = cnt_q;
    if (clear) begin
      state_d    = IDLE;
      deadlock_d = 1'b0;
      idx_d      = '0;
      vec_d      = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyBlock && !progress) begin
            state_d = SUSPECT;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        SUSPECT: begin
          if (progress || !anyBlock) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(THRESHOLD - 1)) begin
            state_d       = DETECTED;
            deadlock_d    = 1'b1;
            reportValid_d = 1'b1;
            idx_d         = lowIdx;
            vec_d         = mon_block;
            cnt_d         = CNT_W'(THRESHOLD);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DETECTED: begin
          // Sticky: progress and block deassertion are deliberately ignored here.
          vec_d = vec_q | mon_block;
          if (anyBlock && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      deadlock_q    <= 1'b0;
      reportValid_q <= 1'b0;
      idx_q         <= '0;
      vec_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      deadlock_q    <= deadlock_d;
      reportValid_q <= reportValid_d;
      idx_q         <= idx_d;
      vec_q         <= vec_d;
      cnt_q         <= cnt_d;
    end
  end

  assign deadlock     = deadlock_q;
  assign report_valid = reportValid_q;
  assign deadlock_idx = idx_q;
  assign block_vec    = vec_q;
  assign block_cycles = cnt_q;

endmodule

// File: tb/tb_yolo_max_pool_top_hls_deadlock_detector.sv
// Self-checking bench: vector table, directed corner sequences and random traffic
// compared against a run-length reference model of the detector.
module tb_yolo_max_pool_top_hls_deadlock_detector;

  localparam int NUM_MON   = 4;
  localparam int THRESHOLD = 8;
  localparam int CNT_W     = 4;
  localparam int IDX_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_MON-1:0] mon_block = '0;
  logic               progress = 1'b0;
  logic               clear = 1'b0;
  logic               deadlock;
  logic               report_valid;
  logic [IDX_W-1:0]   deadlock_idx;
  logic [NUM_MON-1:0] block_vec;
  logic [CNT_W-1:0]   block_cycles;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state: length of the current blocked run plus the latched report.
  bit         mDet;
  int         mRun;
  int         mIdx;
  logic [3:0] mVec;
  int         mCnt;
  bit         mRv;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       prog;
    logic [3:0] mb;
    logic       expDl;
    logic       expRv;
    logic [1:0] expIdx;
    logic [3:0] expVec;
    logic [3:0] expCnt;
  } vecRow_t;

  vecRow_t tbl[13];

  yolo_max_pool_top_hls_deadlock_detector #(
    .NUM_MON(NUM_MON),
    .THRESHOLD(THRESHOLD),
    .CNT_W(CNT_W),
    .IDX_W(IDX_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mon_block(mon_block),
    .progress(progress),
    .clear(clear),
    .deadlock(deadlock),
    .report_valid(report_valid),
    .deadlock_idx(deadlock_idx),
    .block_vec(block_vec),
    .block_cycles(block_cycles)
  );

  always #5 clock = ~clock;

  task automatic modelStep(input bit rst, input bit clr, input bit prog, input logic [3:0] mb);
    bit anyB;
    anyB = (mb != 4'b0);
    mRv = 1'b0;
    if (rst || clr) begin
      mDet = 0; mRun = 0; mIdx = 0; mVec = '0; mCnt = 0;
    end else if (mDet) begin
      mVec = mVec | mb;
      if (anyB && mCnt < CNT_MAX) mCnt = mCnt + 1;
    end else if (anyB && !prog) begin
      mRun = mRun + 1;
      if (mRun == THRESHOLD) begin
        mDet = 1; mRv = 1; mVec = mb; mCnt = THRESHOLD;
        mIdx = -1;
        for (int i = 0; i < NUM_MON; i++) if (mb[i] && mIdx < 0) mIdx = i;
      end else begin
        mCnt = mRun;
      end
    end else begin
      mRun = 0; mCnt = 0;
    end
  endtask

  task automatic checkField(input string name, input string field, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s %s: got %0d, expected %0d at %0t", name, field, actual, expected, $time);
    end
  endtask

  // Drives one edge's worth of inputs, lets the edge happen, then advances the model.
  task automatic applyStimulus(input bit rst, input bit clr, input bit prog, input logic [3:0] mb);
    reset = rst; clear = clr; progress = prog; mon_block = mb;
    @(posedge clock);
    #1;
    modelStep(rst, clr, prog, mb);
  endtask

  task automatic checkOutput(input string name);
    checkField(name, "deadlock", 32'(deadlock), 32'(mDet));
    checkField(name, "report_valid", 32'(report_valid), 32'(mRv));
    checkField(name, "deadlock_idx", 32'(deadlock_idx), mIdx);
    checkField(name, "block_vec", 32'(block_vec), 32'(mVec));
    checkField(name, "block_cycles", 32'(block_cycles), mCnt);
  endtask

  task automatic step(input string name, input bit rst, input bit clr, input bit prog, input logic [3:0] mb);
    applyStimulus(rst, clr, prog, mb);
    checkOutput(name);
  endtask

  task automatic setRow(input int i, input bit rst, input bit clr, input bit prog, input logic [3:0] mb,
                        input bit dl, input bit rv, input logic [1:0] idx, input logic [3:0] vec,
                        input logic [3:0] cnt);
    tbl[i].rst = rst; tbl[i].clr = clr; tbl[i].prog = prog; tbl[i].mb = mb;
    tbl[i].expDl = dl; tbl[i].expRv = rv; tbl[i].expIdx = idx; tbl[i].expVec = vec; tbl[i].expCnt = cnt;
  endtask

  initial begin
    mDet = 0; mRun = 0; mIdx = 0; mVec = '0; mCnt = 0; mRv = 0;

    // Basic detection with mon_block=0100: threshold reached on the 8th high edge.
    setRow(0, 1, 0, 0, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'd0);
    for (int i = 1; i <= 7; i++) setRow(i, 0, 0, 0, 4'b0100, 0, 0, 2'd0, 4'b0000, 4'(i));
    setRow(8,  0, 0, 0, 4'b0100, 1, 1, 2'd2, 4'b0100, 4'd8);
    setRow(9,  0, 0, 0, 4'b0100, 1, 0, 2'd2, 4'b0100, 4'd9);
    setRow(10, 0, 0, 1, 4'b0001, 1, 0, 2'd2, 4'b0101, 4'd10);
    setRow(11, 0, 1, 0, 4'b0001, 0, 0, 2'd0, 4'b0000, 4'd0);
    setRow(12, 0, 0, 0, 4'b0001, 0, 0, 2'd0, 4'b0000, 4'd1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].clr, tbl[i].prog, tbl[i].mb);
      checkField($sformatf("table[%0d]", i), "deadlock", 32'(deadlock), 32'(tbl[i].expDl));
      checkField($sformatf("table[%0d]", i), "report_valid", 32'(report_valid), 32'(tbl[i].expRv));
      checkField($sformatf("table[%0d]", i), "deadlock_idx", 32'(deadlock_idx), 32'(tbl[i].expIdx));
      checkField($sformatf("table[%0d]", i), "block_vec", 32'(block_vec), 32'(tbl[i].expVec));
      checkField($sformatf("table[%0d]", i), "block_cycles", 32'(block_cycles), 32'(tbl[i].expCnt));
    end

    // Glitch restart: 7 high, 1 low, then 8 more high edges needed.
    step("glitchReset", 1, 0, 0, 4'b0000);
    for (int i = 0; i < 7; i++) step("glitchPre", 0, 0, 0, 4'b0001);
    step("glitchLow", 0, 0, 0, 4'b0000);
    for (int i = 0; i < 8; i++) step("glitchPost", 0, 0, 0, 4'b0001);
    checkField("glitchDetect", "deadlock", 32'(deadlock), 1);

    // Progress pulse at edge 4 restarts the count; detection after edge 12.
    step("progReset", 1, 0, 0, 4'b0000);
    for (int i = 0; i < 4; i++) step("progPre", 0, 0, 0, 4'b1010);
    step("progPulse", 0, 0, 1, 4'b1010);
    for (int i = 0; i < 8; i++) step("progPost", 0, 0, 0, 4'b1010);
    checkField("progDetect", "deadlock_idx", 32'(deadlock_idx), 1);

    // Sticky behaviour after detection.
    for (int i = 0; i < 3; i++) step("stickyHigh", 0, 0, 0, 4'b1000);
    for (int i = 0; i < 3; i++) step("stickyLow", 0, 0, i % 2, 4'b0000);
    checkField("stickyVec", "block_vec", 32'(block_vec), 32'(4'b1010));

    // Saturation, clear and re-detection.
    step("satReset", 1, 0, 0, 4'b0000);
    for (int i = 0; i < 40; i++) step("satHold", 0, 0, 0, 4'b0110);
    checkField("satValue", "block_cycles", 32'(block_cycles), CNT_MAX);
    step("satClear", 0, 1, 0, 4'b0110);
    for (int i = 0; i < 8; i++) step("satRedetect", 0, 0, 0, 4'b0110);

    // Clear on the detection edge wins.
    step("clrEdgeReset", 1, 0, 0, 4'b0000);
    for (int i = 0; i < 7; i++) step("clrEdgePre", 0, 0, 0, 4'b0100);
    step("clrEdge", 0, 1, 0, 4'b0100);
    step("clrEdgeAfter", 0, 0, 0, 4'b0100);

    // Reset mid-SUSPECT and mid-DETECTED.
    step("rstMidReset", 1, 0, 0, 4'b0000);
    for (int i = 0; i < 5; i++) step("rstMidSuspect", 0, 0, 0, 4'b0011);
    step("rstInSuspect", 1, 0, 0, 4'b0011);
    for (int i = 0; i < 10; i++) step("rstMidDetect", 0, 0, 0, 4'b0011);
    step("rstInDetect", 1, 0, 0, 4'b0011);

    // Random traffic with long blocked stretches so detections actually occur.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] mb;
      bit rst, clr, prog;
      mb   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 15)) : 4'b0000;
      prog = ($urandom_range(0, 39) == 0);
      clr  = ($urandom_range(0, 149) == 0);
      rst  = ($urandom_range(0, 399) == 0);
      step("random", rst, clr, prog, mb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
